wshb_frame_reader: RTL

Parametrised Wishbone framebuffer reader: the SDRAM-side half of the VGA controller. It fetches a frame of 32-bit pixels (`HDISP` × `VDISP`, row-major from `BASE_ADDR`) using incrementing bursts and pushes each returned word into the write port of the pixel `async_fifo`. The FIFO's almost-full flag throttles it, and it restarts the frame on request. It runs entirely in the Wishbone clock domain; the pixel-clock side only reads the FIFO.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/wshb_frame_reader_if.sv | 24 ++
 rtl/wshb_frame_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: video timing, Wishbone cycle-type codes and the
// framebuffer reader state encoding.
package vga_pkg;

  localparam int unsigned HFP    = 40;
  localparam int unsigned HPULSE = 48;
  localparam int unsigned HBP    = 40;
  localparam int unsigned VFP    = 13;
  localparam int unsigned VPULSE = 3;
  localparam int unsigned VBP    = 29;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/wshb_frame_reader_if.sv
// Wishbone B4 read-master bus bundle used between the frame reader and SDRAM.
interface wshb_frame_reader_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, cti, bte,
    input  dat_sm, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/wshb_frame_reader.sv
// Framebuffer reader: streams a frame of 32-bit pixels from Wishbone memory
// into the pixel FIFO using incrementing bursts, throttled by almost-full.
module wshb_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       restart,
  wshb_frame_reader_if.master        wshb,
  output logic [31:0]                fifo_wdata,
  output logic                       fifo_write,
  input  logic                       fifo_walmost_full,
  output logic                       frame_done
);

  localparam int unsigned NPIX   = HDISP * VDISP;
  localparam int unsigned IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NPIX - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [2:0] CTI_FIRST = (BURST_LEN == 1) ? CTI_END : CTI_INCR;

  // Bursts must tile the frame exactly so none straddles the index wrap.
  generate
    if (BURST_LEN == 0 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
      $error("BURST_LEN must be a power of two >= 1");
    end else if (NPIX % BURST_LEN != 0) begin : g_bad_frame
      $error("HDISP*VDISP must be a multiple of BURST_LEN");
    end
  endgenerate

  rd_state_t         r_state, w_state_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic [BEAT_W-1:0] r_beat, w_beat_n;
  logic              r_restart_pend, w_restart_pend_n;
  logic              r_cyc, w_cyc_n;
  logic [31:0]       r_adr, w_adr_n;
  logic [2:0]        r_cti, w_cti_n;
  logic              r_fifo_write, w_fifo_write_n;
  logic [31:0]       r_fifo_wdata, w_fifo_wdata_n;
  logic              r_frame_done, w_frame_done_n;

  logic              w_ack_beat;
  logic              w_restart_any;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [BEAT_W-1:0] w_beat_inc;

  assign w_ack_beat    = (r_state == RD_BURST) && wshb.ack;
  assign w_restart_any = r_restart_pend | restart;
  assign w_idx_inc     = (r_idx == IDX_LAST) ? '0 : IDX_W'(r_idx + 1'b1);
  assign w_beat_inc    = BEAT_W'(r_beat + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RD_IDLE;
      r_idx          <= '0;
      r_beat         <= '0;
      r_restart_pend <= 1'b0;
      r_cyc          <= 1'b0;
      r_adr          <= BASE_ADDR;
      r_cti          <= CTI_CLASSIC;
      r_fifo_write   <= 1'b0;
      r_fifo_wdata   <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_idx          <= w_idx_n;
      r_beat         <= w_beat_n;
      r_restart_pend <= w_restart_pend_n;
      r_cyc          <= w_cyc_n;
      r_adr          <= w_adr_n;
      r_cti          <= w_cti_n;
      r_fifo_write   <= w_fifo_write_n;
      r_fifo_wdata   <= w_fifo_wdata_n;
      r_frame_done   <= w_frame_done_n;
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_idx_n          = r_idx;
    w_beat_n         = r_beat;
    w_restart_pend_n = r_restart_pend;
    w_cyc_n          = r_cyc;
    w_adr_n          = r_adr;
    w_cti_n          = r_cti;
    w_fifo_write_n   = w_ack_beat;
    w_fifo_wdata_n   = w_ack_beat ? wshb.dat_sm : r_fifo_wdata;
    // A pending restart suppresses the end-of-frame pulse.
    w_frame_done_n   = w_ack_beat && (r_idx == IDX_LAST) && !w_restart_any;

    unique case (r_state)
      RD_IDLE: begin
        w_restart_pend_n = 1'b0;
        if (restart) begin
          w_idx_n = '0;
        end
        if (enable && !fifo_walmost_full) begin
          w_state_n = RD_BURST;
          w_cyc_n   = 1'b1;
          w_adr_n   = BASE_ADDR + (32'(w_idx_n) << 2);
          w_cti_n   = CTI_FIRST;
          w_beat_n  = '0;
        end
      end
      RD_BURST: begin
        if (restart) begin
          w_restart_pend_n = 1'b1;
        end
        if (wshb.ack) begin
          w_adr_n = r_adr + 32'd4;
          if (r_beat == BEAT_LAST) begin
            w_state_n        = RD_IDLE;
            w_cyc_n          = 1'b0;
            w_cti_n          = CTI_CLASSIC;
            w_beat_n         = '0;
            w_idx_n          = w_restart_any ? '0 : w_idx_inc;
            w_restart_pend_n = 1'b0;
          end else begin
            w_beat_n = w_beat_inc;
            w_idx_n  = w_idx_inc;
            w_cti_n  = (w_beat_inc == BEAT_LAST) ? CTI_END : CTI_INCR;
          end
        end
      end
      default: begin
        w_state_n = RD_IDLE;
      end
    endcase
  end

  assign wshb.cyc   = r_cyc;
  assign wshb.stb   = r_cyc;
  assign wshb.we    = 1'b0;
  assign wshb.sel   = 4'hF;
  assign wshb.adr   = r_adr;
  assign wshb.cti   = r_cti;
  assign wshb.bte   = 2'b00;
  assign fifo_write = r_fifo_write;
  assign fifo_wdata = r_fifo_wdata;
  assign frame_done = r_frame_done;

endmodule
